// File: rtl/redux_loader_if.sv
// Handshake bundle around the redux loader: the byte stream in, and the
// instruction-memory write port out. The loader is the slave side; the
// stream source / memory pair is the master side.
interface redux_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/redux_loader.sv
// Boot-time program loader for the redux core. Takes a length-prefixed byte
// stream (L, N data bytes, checksum), writes the data into instruction memory
// from address 0, verifies the additive checksum and then releases the core.
module redux_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    redux_loader_if.slave     bus,
    output logic              core_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    // L = 0 encodes a full memory image of 2^ADDR_W bytes.
    localparam logic [ADDR_W:0] FULL_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W:0]   n_bytes;
    logic [DATA_W-1:0] sum;
    logic [ADDR_W:0]   count_inc;
    logic              xfer;

    // Stream is accepted in the three loading states only; the reset term
    // keeps in_ready low for as long as reset is held, and lets it rise in
    // LEN the moment reset is released.
    assign bus.in_ready = !reset &&
                          (state == S_LEN || state == S_DATA || state == S_CHECK);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign count_inc    = count + COUNT_ONE;

    // Loader FSM with all outputs registered; the write port is a one-cycle
    // strobe issued on the cycle after each data-byte transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_LEN;
            n_bytes        <= '0;
            sum            <= '0;
            count          <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_reset     <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below reads the pre-edge values of count, sum and state.
            bus.imem_we <= 1'b0;
            case (state)
                S_LEN: begin
                    if (xfer) begin
                        n_bytes <= (bus.in_data == '0) ? FULL_LEN
                                                       : (ADDR_W+1)'(bus.in_data);
                        count   <= '0;
                        sum     <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= count[ADDR_W-1:0];
                        bus.imem_wdata <= bus.in_data;
                        sum            <= sum + bus.in_data;
                        count          <= count_inc;
                        if (count_inc == n_bytes) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        if (bus.in_data == sum) begin
                            core_reset <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_RUN;
                        end else begin
                            err   <= 1'b1;
                            state <= S_ERROR;
                        end
                    end
                end
                S_RUN, S_ERROR: begin
                    if (load) begin
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        state      <= S_LEN;
                    end
                end
                default: begin
                    core_reset <= 1'b1;
                    done       <= 1'b0;
                    err        <= 1'b0;
                    state      <= S_LEN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_redux_loader.sv
// Testbench for redux_loader: a table of per-cycle vectors for the nominal,
// bad-checksum and reload flows, then hand-written sequences for gapped
// input, a full 256-byte image and an asynchronous reset mid-load.
module tb_redux_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       core_reset;
    logic       done;
    logic       err;
    logic [8:0] count;

    redux_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    redux_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .bus        (bus),
        .core_reset (core_reset),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Instruction-memory model: captures a write at the edge where imem_we is high.
    logic [7:0] mem [256];
    int         wr_cnt = 0;
    always @(posedge clk) begin
        if (bus.imem_we) begin
            mem[bus.imem_addr] <= bus.imem_wdata;
            wr_cnt             <= wr_cnt + 1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted byte; valid drops after the edge unless the caller re-raises it.
    task automatic xfer(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    typedef struct {
        logic       ld;
        logic       vld;
        logic [7:0] din;
        logic       rdy;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       crst;
        logic       dn;
        logic       er;
        logic [8:0] cnt;
    } vec_t;

    localparam int NV = 22;
    vec_t v [NV];

    initial begin
        logic [7:0] nom [5];
        int         wc0;

        // Expected values are the outputs just after the edge that applies the inputs.
        v = '{
            // nominal 03,17,2F,4A,90
            '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0},
            '{1'b0, 1'b1, 8'h17, 1'b1, 1'b1, 8'h00, 8'h17, 1'b1, 1'b0, 1'b0, 9'd1},
            '{1'b0, 1'b1, 8'h2F, 1'b1, 1'b1, 8'h01, 8'h2F, 1'b1, 1'b0, 1'b0, 9'd2},
            '{1'b0, 1'b1, 8'h4A, 1'b1, 1'b1, 8'h02, 8'h4A, 1'b1, 1'b0, 1'b0, 9'd3},
            '{1'b0, 1'b1, 8'h90, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9'd3},
            // byte offered in RUN is ignored
            '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9'd3},
            // reload from RUN
            '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd3},
            // bad checksum 02,10,20,31 (sum 30)
            '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0},
            '{1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0, 9'd1},
            '{1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 8'h01, 8'h20, 1'b1, 1'b0, 1'b0, 9'd2},
            '{1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 9'd2},
            '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 9'd2},
            // recover: load, then 01,05,05
            '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd2},
            '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0},
            '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 9'd1},
            '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9'd1},
            // reload from RUN, then load held through LEN, DATA and CHECK
            '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd1},
            '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd1},
            '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 9'd0},
            '{1'b1, 1'b1, 8'hAB, 1'b1, 1'b1, 8'h00, 8'hAB, 1'b1, 1'b0, 1'b0, 9'd1},
            '{1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9'd1},
            '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 9'd1}
        };

        reset        = 1'b1;
        load         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state while reset is held.
        #2;
        check("rst.in_ready",   32'(bus.in_ready),   32'd0);
        check("rst.imem_we",    32'(bus.imem_we),    32'd0);
        check("rst.imem_addr",  32'(bus.imem_addr),  32'd0);
        check("rst.imem_wdata", 32'(bus.imem_wdata), 32'd0);
        check("rst.core_reset", 32'(core_reset),     32'd1);
        check("rst.done",       32'(done),           32'd0);
        check("rst.err",        32'(err),            32'd0);
        check("rst.count",      32'(count),          32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst.ready_after_release", 32'(bus.in_ready), 32'd1);

        // Table-driven flows.
        for (int i = 0; i < NV; i++) begin
            load         = v[i].ld;
            bus.in_valid = v[i].vld;
            bus.in_data  = v[i].din;
            tick();
            load         = 1'b0;
            bus.in_valid = 1'b0;
            check($sformatf("v%0d.in_ready", i),   32'(bus.in_ready), 32'(v[i].rdy));
            check($sformatf("v%0d.imem_we", i),    32'(bus.imem_we),  32'(v[i].we));
            if (v[i].we) begin
                check($sformatf("v%0d.imem_addr", i),  32'(bus.imem_addr),  32'(v[i].addr));
                check($sformatf("v%0d.imem_wdata", i), 32'(bus.imem_wdata), 32'(v[i].wd));
            end
            check($sformatf("v%0d.core_reset", i), 32'(core_reset), 32'(v[i].crst));
            check($sformatf("v%0d.done", i),       32'(done),       32'(v[i].dn));
            check($sformatf("v%0d.err", i),        32'(err),        32'(v[i].er));
            check($sformatf("v%0d.count", i),      32'(count),      32'(v[i].cnt));
        end
        check("table.mem0", 32'(mem[0]), 32'h0000_00AB);

        // Gapped stream: two idle cycles between every byte, same image as nominal.
        nom = '{8'h03, 8'h17, 8'h2F, 8'h4A, 8'h90};
        pulse_load();
        wc0 = wr_cnt;
        for (int j = 0; j < 5; j++) begin
            xfer(nom[j]);
            check($sformatf("gap.b%0d.imem_we", j), 32'(bus.imem_we),
                  (j >= 1 && j <= 3) ? 32'd1 : 32'd0);
            if (j >= 1 && j <= 3) begin
                check($sformatf("gap.b%0d.addr", j),  32'(bus.imem_addr),  32'(j - 1));
                check($sformatf("gap.b%0d.wdata", j), 32'(bus.imem_wdata), 32'(nom[j]));
            end
            for (int g = 0; g < 2; g++) begin
                tick();
                check($sformatf("gap.b%0d.idle%0d.imem_we", j, g), 32'(bus.imem_we), 32'd0);
            end
        end
        check("gap.writes", 32'(wr_cnt - wc0), 32'd3);
        check("gap.mem0",   32'(mem[0]), 32'h17);
        check("gap.mem1",   32'(mem[1]), 32'h2F);
        check("gap.mem2",   32'(mem[2]), 32'h4A);
        check("gap.done",   32'(done), 32'd1);
        check("gap.core_reset", 32'(core_reset), 32'd0);

        // Full 256-byte image: L=00, data = address, checksum 80.
        pulse_load();
        wc0 = wr_cnt;
        xfer(8'h00);
        for (int a = 0; a < 256; a++) begin
            xfer(8'(a));
        end
        check("full.last_we",    32'(bus.imem_we),   32'd1);
        check("full.last_addr",  32'(bus.imem_addr), 32'd255);
        check("full.count",      32'(count),         32'd256);
        check("full.in_ready",   32'(bus.in_ready),  32'd1);
        check("full.done_early", 32'(done),          32'd0);
        xfer(8'h80);
        check("full.done",       32'(done),          32'd1);
        check("full.core_reset", 32'(core_reset),    32'd0);
        check("full.err",        32'(err),           32'd0);
        check("full.writes",     32'(wr_cnt - wc0),  32'd256);
        check("full.mem80",      32'(mem[128]),      32'h80);
        check("full.memFF",      32'(mem[255]),      32'hFF);

        // Asynchronous reset after 2 of 3 data bytes, mid-cycle.
        pulse_load();
        xfer(8'h03);
        xfer(8'h17);
        xfer(8'h2F);
        wc0 = wr_cnt;
        #2;
        reset = 1'b1;
        #1;
        check("arst.imem_we",    32'(bus.imem_we),   32'd0);
        check("arst.imem_addr",  32'(bus.imem_addr), 32'd0);
        check("arst.in_ready",   32'(bus.in_ready),  32'd0);
        check("arst.core_reset", 32'(core_reset),    32'd1);
        check("arst.done",       32'(done),          32'd0);
        check("arst.count",      32'(count),         32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("arst.no_writes",  32'(wr_cnt - wc0),  32'd0);
        check("arst.ready_len",  32'(bus.in_ready),  32'd1);
        xfer(8'h02);
        xfer(8'hAA);
        xfer(8'h55);
        xfer(8'hFF);
        check("arst.done",  32'(done), 32'd1);
        check("arst.count", 32'(count), 32'd2);
        tick();
        check("arst.mem0", 32'(mem[0]), 32'hAA);
        check("arst.mem1", 32'(mem[1]), 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/redux_loader.md
# redux_loader

Boot-time program loader for the 8-bit redux core. Accepts a length-prefixed byte stream over a valid/ready handshake and writes it into the core's 256-byte instruction memory starting at address 0. Verifies an 8-bit additive checksum, then releases the core from reset. It sits directly upstream of the redux core and drives its instruction-memory write port and its reset.

## Interface
- `ADDR_W`, default 8: instruction-memory address width. Maximum program size is 2^ADDR_W bytes.
- `DATA_W`, default 8: instruction/byte width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  **asynchronous, active-high** reset.
- `load`  in  1  one-cycle pulse; restarts loading from RUN or ERROR.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  DATA_W  stream byte.
- `in_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  DATA_W  write data.
- `core_reset`  out  1  reset to the redux core; 1 holds the core.
- `done`  out  1  program loaded and verified; core running.
- `err`  out  1  checksum mismatch.
- `count`  out  ADDR_W+1  number of data bytes written so far.

## Operation
- A transfer occurs on a rising edge when `in_valid && in_ready`. No other edge changes stream state.
- Stream format: a length byte L, then N data bytes, then one checksum byte. N = L, except L=0 means N=256 (2^ADDR_W).
- Checksum = sum of the N data bytes mod 2^DATA_W. The length byte is excluded.
- States:
  - **LEN**: `in_ready`=1. On transfer, latch N; clear the address and sum; go to DATA.
  - **DATA**: `in_ready`=1. On each transfer, register a write to the current address, add the byte to the sum, and increment the address. After the N-th byte, go to CHECK.
  - **CHECK**: `in_ready`=1. On transfer, if the byte equals the sum, go to RUN; otherwise go to ERROR.
  - **RUN**: `in_ready`=0, `core_reset`=0, `done`=1.
  - **ERROR**: `in_ready`=0, `core_reset`=1, `err`=1.
- `load` is honoured only in RUN or ERROR; the next state is LEN. `load` is ignored in LEN, DATA and CHECK.
- Leaving RUN via `load` asserts `core_reset` on that same edge.
- Address counter is ADDR_W bits. For N=256 the last write goes to address 255. The counter wrap is harmless because the state leaves DATA.
- `count` is ADDR_W+1 bits so that it can represent 256.
- Bytes offered while `in_ready`=0 are not consumed and have no effect.

## Timing
- Reset values, applied asynchronously and held while `reset`=1:
  - state = LEN
  - `in_ready`=0 while `reset` is asserted, then 1 in LEN
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `core_reset`=1, `done`=0, `err`=0, `count`=0
- Write latency is 1 cycle. For a data-byte transfer at edge k, `imem_we`=1 with the matching addr/data is held during the cycle after edge k and sampled by memory at edge k+1. `imem_we` is 0 in every other cycle.
- `count` increments on the transfer edge itself.
- Back-to-back transfers give one write per cycle. Gaps in `in_valid` insert cycles with `imem_we`=0.
- Checksum transfer at edge k:
  - `core_reset` falls and `done` rises, both registered at edge k.
  - The core executes from PC 0 starting at edge k+1.
  - The final data write is complete at edge k at the latest, so memory is consistent before the core runs.
- `err` rises at the checksum edge on mismatch. `core_reset` never deasserts in that case.
- `load` at edge k: `done`/`err` clear and `core_reset`=1 at edge k. `in_ready`=1 during the cycle after edge k.
- Reset asserted mid-load: the load aborts immediately with no further writes. Memory contents are left as partially written. After release, the loader waits in LEN.

## Test plan
- **Nominal 3-byte load.** Stream 03,17,2F,4A,90 with valid held high. Writes 0→17, 1→2F, 2→4A on consecutive cycles. `count`=3. `core_reset` falls and `done`=1 at the checksum edge.
- **Bad checksum.** Stream 02,10,20,31. Writes occur at 0 and 1. `err`=1, `core_reset` stays 1, `in_ready`=0. `load` pulse then stream 01,05,05: `err` clears, `done`=1.
- **Backpressure and gaps.** Same as the nominal load with `in_valid` low for 2 cycles between every byte. Identical memory image, each write one cycle after its transfer, no spurious `imem_we`.
- **Full 256-byte load.** L=00, data = address value (00..FF), checksum 80. Last write goes to addr 255, `count`=256, `done`=1.
- **Async reset mid-DATA.** Assert `reset` asynchronously after 2 of 3 data bytes. Outputs return immediately to reset values with no further writes. A following full stream loads correctly.
- **Reload from RUN.** Pulse `load` while `done`=1. `core_reset`=1 at the same edge, `load` pulses in LEN are ignored, and a new program overwrites from address 0.
